// File: rtl/l2_cache_control.sv
// l2_cache_control: direct-mapped, write-back, write-allocate 16-line L2 controller with tag store.
// The request is latched in IDLE so upstream may drop it mid-operation; memory strobes decode from state only.
module l2_cache_control #(
    parameter int width    = 128,
    parameter int tag_bits = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic [15:0]      mem_address_i,
    input  logic [width-1:0] mem_wdata_i,
    output logic [width-1:0] mem_rdata_o,
    output logic             mem_resp_o,
    output logic             pmem_read_o,
    output logic             pmem_write_o,
    output logic [15:0]      pmem_address_o,
    output logic [width-1:0] pmem_wdata_o,
    input  logic [width-1:0] pmem_rdata_i,
    input  logic             pmem_resp_i,
    output logic             array_write_o,
    output logic [3:0]       array_index_o,
    output logic [width-1:0] array_datain_o,
    input  logic [width-1:0] array_dataout_i
);
    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_e;

    state_e              state_q, state_d;
    logic [15:4]         addr_q;
    logic [width-1:0]    wdata_q;
    logic                is_write_q;
    logic [tag_bits-1:0] tag_q [16];
    logic [15:0]         valid_q, valid_d, dirty_q, dirty_d;
    logic [3:0]          idx;
    logic [tag_bits-1:0] ltag;
    logic                hit;
    logic                unused;

    assign unused         = ^mem_address_i[3:0];
    assign idx            = addr_q[7:4];
    assign ltag           = addr_q[15:8];
    assign hit            = valid_q[idx] && tag_q[idx] == ltag;
    assign mem_rdata_o    = array_dataout_i;
    assign pmem_wdata_o   = array_dataout_i;
    assign array_index_o  = state_q == IDLE ? mem_address_i[7:4] : idx;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tags and the request latch need no reset: valid=0 and IDLE mask them.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && (mem_read_i || mem_write_i)) begin
            addr_q     <= mem_address_i[15:4];
            wdata_q    <= mem_wdata_i;
            is_write_q <= mem_write_i;
        end
        if (state_q == ALLOCATE && pmem_resp_i)
            tag_q[idx] <= ltag;
    end

    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        mem_resp_o     = 1'b0;
        pmem_read_o    = 1'b0;
        pmem_write_o   = 1'b0;
        array_write_o  = 1'b0;
        array_datain_o = wdata_q;
        pmem_address_o = {ltag, idx, 4'h0};
        case (state_q)
            IDLE: state_d = (mem_read_i || mem_write_i) ? COMPARE : IDLE;
            COMPARE: begin
                if (hit) begin
                    mem_resp_o    = 1'b1;
                    array_write_o = is_write_q;
                    dirty_d[idx]  = dirty_q[idx] | is_write_q;
                    state_d       = IDLE;
                end else
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                pmem_write_o   = 1'b1;
                pmem_address_o = {tag_q[idx], idx, 4'h0};
                if (pmem_resp_i) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read_o    = 1'b1;
                array_datain_o = pmem_rdata_i;
                if (pmem_resp_i) begin
                    array_write_o = 1'b1;
                    valid_d[idx]  = 1'b1;
                    dirty_d[idx]  = 1'b0;
                    state_d       = COMPARE;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_l2_cache_control.sv
// tb_l2_cache_control: random L1 traffic against a line-level cache/memory model, plus directed scenarios.
module tb_l2_cache_control;
    logic         clk, reset;
    logic         mem_read, mem_write, mem_resp;
    logic [15:0]  mem_address, pmem_address;
    logic [127:0] mem_wdata, mem_rdata, pmem_wdata, pmem_rdata, array_datain, array_dataout;
    logic         pmem_read, pmem_write, pmem_resp, array_write;
    logic [3:0]   array_index;

    logic [127:0] arr [16];
    logic [127:0] pmem [logic [15:0]];
    logic [127:0] m_data [16];
    logic [7:0]   m_tag [16];
    logic         m_valid [16];
    logic         m_dirty [16];
    int           checks = 0, errors = 0;

    l2_cache_control dut (
        .clk_i(clk), .reset_i(reset),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .mem_address_i(mem_address),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_resp_o(mem_resp),
        .pmem_read_o(pmem_read), .pmem_write_o(pmem_write), .pmem_address_o(pmem_address),
        .pmem_wdata_o(pmem_wdata), .pmem_rdata_i(pmem_rdata), .pmem_resp_i(pmem_resp),
        .array_write_o(array_write), .array_index_o(array_index),
        .array_datain_o(array_datain), .array_dataout_i(array_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign array_dataout = arr[array_index];
    always @(posedge clk) if (array_write) arr[array_index] <= array_datain;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mem_line(input logic [15:0] a);
        if (!pmem.exists(a)) pmem[a] = {$urandom, $urandom, $urandom, $urandom};
        return pmem[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [15:0] a, input logic [127:0] d);
        logic [3:0]   idx;
        logic [15:0]  line, wb_addr;
        logic [127:0] wb_data, fill;
        bit           hit, exp_wb, saw_wb, saw_rd;
        int           cyc, last;
        idx     = a[7:4];
        line    = {a[15:4], 4'h0};
        hit     = m_valid[idx] && m_tag[idx] == a[15:8];
        exp_wb  = !hit && m_valid[idx] && m_dirty[idx];
        wb_addr = {m_tag[idx], idx, 4'h0};
        wb_data = m_data[idx];
        fill    = hit ? m_data[idx] : mem_line(line);
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = d;
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        mem_address = 16'($urandom); mem_wdata = {$urandom, $urandom, $urandom, $urandom};
        cyc = 1; last = 0; saw_wb = 0; saw_rd = 0;
        while (!mem_resp && cyc < 100) begin
            check("excl", {127'b0, pmem_read & pmem_write}, 128'b0);
            if (pmem_write && $urandom_range(0, 2) == 0) begin
                check("wb_addr", {112'b0, pmem_address}, {112'b0, wb_addr});
                check("wb_data", pmem_wdata, wb_data);
                saw_wb = 1; pmem_resp = 1'b1; last = cyc;
            end else if (pmem_read && $urandom_range(0, 2) == 0) begin
                check("rd_addr", {112'b0, pmem_address}, {112'b0, line});
                check("rd_after_wb", {127'b0, saw_wb}, {127'b0, exp_wb});
                pmem_rdata = pmem[line];
                saw_rd = 1; pmem_resp = 1'b1; last = cyc;
            end
            @(negedge clk);
            pmem_resp = 1'b0;
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            cyc++;
        end
        if (exp_wb) pmem[wb_addr] = wb_data;
        if (!hit) begin
            m_data[idx] = fill; m_tag[idx] = a[15:8]; m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            m_data[idx] = d; m_dirty[idx] = 1'b1;
        end
        check("resp", {127'b0, mem_resp}, 128'b1);
        if (mem_resp) begin
            check("resp_pmem_idle", {126'b0, pmem_read, pmem_write}, 128'b0);
            check("resp_awrite", {127'b0, array_write}, {127'b0, wr});
            if (!wr) check("rdata", mem_rdata, m_data[idx]);
            check("saw_wb", {127'b0, saw_wb}, {127'b0, exp_wb});
            check("saw_rd", {127'b0, saw_rd}, {127'b0, !hit});
            check("latency", 128'(hit ? cyc : cyc - last), 128'd1);
        end
        @(negedge clk);
        check("resp_pulse", {127'b0, mem_resp}, 128'b0);
        check("array", arr[idx], m_data[idx]);
    endtask

    initial begin
        logic [15:0] a;
        int          n;
        reset = 1'b1; mem_read = 0; mem_write = 0; mem_address = 0; mem_wdata = 0;
        pmem_resp = 0; pmem_rdata = 0;
        clear_model();
        @(negedge clk); @(negedge clk);
        check("rst_strobes", {124'b0, mem_resp, pmem_read, pmem_write, array_write}, 128'b0);
        reset = 1'b0;

        pmem[16'h1230] = {32{4'hA}};
        do_req(1, 0, 16'h1230, '0);
        check("fill_tp", m_data[3], {32{4'hA}});
        do_req(1, 0, 16'h123C, '0);
        do_req(0, 1, 16'h1230, {32{4'h5}});
        do_req(1, 0, 16'h4430, '0);
        check("wb_tp", pmem[16'h1230], {32{4'h5}});
        do_req(1, 1, 16'h0050, {4{32'hC0DE_F00D}});
        do_req(1, 0, 16'h0050, '0);

        // Reset arriving while a fill is outstanding.
        @(negedge clk);
        mem_read = 1'b1; mem_address = 16'h0990;
        @(negedge clk);
        mem_read = 1'b0;
        n = 0;
        while (!pmem_read && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("alloc_pending", {127'b0, pmem_read}, 128'b1);
        #2 reset = 1'b1;
        #1 check("rst_async", {126'b0, pmem_read, array_write}, 128'b0);
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        do_req(1, 0, 16'h0990, '0);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: a[15:8] = 8'h12;
                1: a[15:8] = 8'h44;
                2: a[15:8] = 8'h7F;
                default: a[15:8] = 8'($urandom);
            endcase
            a[7:0] = 8'($urandom);
            n = $urandom_range(0, 2);
            do_req(n != 1, n != 0, a, {$urandom, $urandom, $urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
